// File: rtl/ct_mmu_dutlb_pkg.sv
// Shared definitions for the data uTLB refill controller: FSM state
// encoding and the default VPN/PPN/flag widths.
package ct_mmu_dutlb_pkg;

   localparam int VPN_WIDTH = 27;
   localparam int PPN_WIDTH = 28;
   localparam int FLG_WIDTH = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_UPD  = 2'b11
   } state_e;

   // Width of a pointer that can index n entries (at least one bit).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ct_mmu_dutlb_refill_ctrl_if.sv
// uTLB <-> jTLB refill handshake. The uTLB side is the master (raises the
// request), the jTLB side is the slave (grants and returns refill data).
interface ct_mmu_dutlb_refill_ctrl_if #(
   parameter int VPN_WIDTH = ct_mmu_dutlb_pkg::VPN_WIDTH,
   parameter int PPN_WIDTH = ct_mmu_dutlb_pkg::PPN_WIDTH,
   parameter int FLG_WIDTH = ct_mmu_dutlb_pkg::FLG_WIDTH
);
   logic                 utlb_jtlb_req;
   logic [VPN_WIDTH-1:0] utlb_jtlb_vpn;
   logic                 jtlb_utlb_grant;
   logic                 jtlb_utlb_refill_vld;
   logic                 jtlb_utlb_fault;
   logic [PPN_WIDTH-1:0] jtlb_utlb_ppn;
   logic [FLG_WIDTH-1:0] jtlb_utlb_flg;

   modport master (
      output utlb_jtlb_req,
      output utlb_jtlb_vpn,
      input  jtlb_utlb_grant,
      input  jtlb_utlb_refill_vld,
      input  jtlb_utlb_fault,
      input  jtlb_utlb_ppn,
      input  jtlb_utlb_flg
   );

   modport slave (
      input  utlb_jtlb_req,
      input  utlb_jtlb_vpn,
      output jtlb_utlb_grant,
      output jtlb_utlb_refill_vld,
      output jtlb_utlb_fault,
      output jtlb_utlb_ppn,
      output jtlb_utlb_flg
   );
endinterface

// File: rtl/ct_mmu_dutlb_victim_sel.sv
// Victim picker for a uTLB refill: lowest-index invalid entry if any,
// otherwise the round-robin pointer, which then advances (with wrap).
module ct_mmu_dutlb_victim_sel #(
   parameter int ENTRY_NUM = 17,
   parameter int PTR_W     = 5
) (
   input  logic [ENTRY_NUM-1:0] entry_vld,
   input  logic [PTR_W-1:0]     rr_ptr,
   output logic [ENTRY_NUM-1:0] victim,
   output logic [PTR_W-1:0]     rr_ptr_next
);

   // inv_below[i] is set when some entry below index i is invalid
   logic [ENTRY_NUM:0]   inv_below;
   logic [ENTRY_NUM-1:0] victim_inv;
   logic [ENTRY_NUM-1:0] victim_rr;
   logic                 all_vld;

   assign inv_below[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
         assign inv_below[gi+1] = inv_below[gi] | ~entry_vld[gi];
         assign victim_inv[gi]  = ~entry_vld[gi] & ~inv_below[gi];
         assign victim_rr[gi]   = (rr_ptr == PTR_W'(gi));
      end
   endgenerate

   assign all_vld = ~inv_below[ENTRY_NUM];

   // Pointer only moves when it was actually used to pick the victim
   always_comb begin
      victim      = all_vld ? victim_rr : victim_inv;
      rr_ptr_next = rr_ptr;
      if (all_vld) begin
         rr_ptr_next = (rr_ptr == PTR_W'(ENTRY_NUM-1)) ? '0 : rr_ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/ct_mmu_dutlb_refill_ctrl.sv
// Data uTLB miss/refill controller. Detects misses on the two LSU lookup
// ports, requests a translation from the jTLB for one of them (port 0
// first), and on refill writes a chosen victim entry with a one-cycle
// one-hot update. Flushes abandon or discard an in-flight refill.
// Optional: define CT_MMU_DUTLB_MISS_CNT_EN to add the utlb_miss_cnt output.
module ct_mmu_dutlb_refill_ctrl #(
   parameter int ENTRY_NUM = 17,
   parameter int VPN_WIDTH = ct_mmu_dutlb_pkg::VPN_WIDTH,
   parameter int PPN_WIDTH = ct_mmu_dutlb_pkg::PPN_WIDTH,
   parameter int FLG_WIDTH = ct_mmu_dutlb_pkg::FLG_WIDTH
) (
   input  logic                    utlb_entry_clk,
   input  logic                    cpurst_b,
   input  logic [ENTRY_NUM-1:0]    entry_vld,
   input  logic [ENTRY_NUM-1:0]    entry_hit0,
   input  logic [ENTRY_NUM-1:0]    entry_hit1,
   input  logic                    lsu_req0_vld,
   input  logic                    lsu_req1_vld,
   input  logic [VPN_WIDTH-1:0]    lsu_req_vpn0,
   input  logic [VPN_WIDTH-1:0]    lsu_req_vpn1,
   input  logic                    regs_utlb_clr,
   input  logic                    tlboper_utlb_clr,
   ct_mmu_dutlb_refill_ctrl_if.master jtlb,
   output logic [ENTRY_NUM-1:0]    utlb_entry_upd,
   output logic [VPN_WIDTH-1:0]    utlb_upd_vpn,
   output logic [PPN_WIDTH-1:0]    utlb_upd_ppn,
   output logic [FLG_WIDTH-1:0]    utlb_upd_flg,
   output logic                    utlb_miss0,
   output logic                    utlb_miss1,
   output logic                    utlb_fault_vld,
   output logic                    utlb_fault_port
`ifdef CT_MMU_DUTLB_MISS_CNT_EN
   ,
   output logic [31:0]             utlb_miss_cnt
`endif
);

   import ct_mmu_dutlb_pkg::*;

   localparam int PTR_W = ptr_width(ENTRY_NUM);

   state_e               state_q, state_d;
   logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
   logic                 port_q, port_d;
   logic                 drop_q, drop_d;
   logic [VPN_WIDTH-1:0] upd_vpn_q, upd_vpn_d;
   logic [PPN_WIDTH-1:0] upd_ppn_q, upd_ppn_d;
   logic [FLG_WIDTH-1:0] upd_flg_q, upd_flg_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 fault_vld_q, fault_vld_d;
   logic                 fault_port_q, fault_port_d;

   logic                 clr;
   logic                 hit0_any, hit1_any;
   logic                 miss0, miss1;
   logic                 req_c;
   logic [ENTRY_NUM-1:0] upd_c;
   logic [ENTRY_NUM-1:0] victim;
   logic [PTR_W-1:0]     rr_ptr_next;

   assign clr      = regs_utlb_clr | tlboper_utlb_clr;
   assign hit0_any = |(entry_hit0 & entry_vld);
   assign hit1_any = |(entry_hit1 & entry_vld);
   assign miss0    = lsu_req0_vld & ~hit0_any;
   assign miss1    = lsu_req1_vld & ~hit1_any;

   ct_mmu_dutlb_victim_sel #(
      .ENTRY_NUM (ENTRY_NUM),
      .PTR_W     (PTR_W)
   ) u_victim_sel (
      .entry_vld   (entry_vld),
      .rr_ptr      (rr_ptr_q),
      .victim      (victim),
      .rr_ptr_next (rr_ptr_next)
   );

   // Next-state and output decode for the refill FSM
   always_comb begin
      state_d      = state_q;
      vpn_d        = vpn_q;
      port_d       = port_q;
      drop_d       = drop_q;
      upd_vpn_d    = upd_vpn_q;
      upd_ppn_d    = upd_ppn_q;
      upd_flg_d    = upd_flg_q;
      rr_ptr_d     = rr_ptr_q;
      fault_vld_d  = 1'b0;
      fault_port_d = fault_port_q;
      req_c        = 1'b0;
      upd_c        = '0;
      case (state_q)
         ST_IDLE: begin
            if (miss0) begin
               vpn_d   = lsu_req_vpn0;
               port_d  = 1'b0;
               state_d = ST_REQ;
            end else if (miss1) begin
               vpn_d   = lsu_req_vpn1;
               port_d  = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // A flush may withdraw the request only before it is granted
            if (clr) begin
               state_d = ST_IDLE;
            end else begin
               req_c = 1'b1;
               if (jtlb.jtlb_utlb_grant) begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (jtlb.jtlb_utlb_refill_vld) begin
               state_d = ST_IDLE;
               if (drop_q || clr) begin
                  drop_d = 1'b0;
               end else if (jtlb.jtlb_utlb_fault) begin
                  fault_vld_d  = 1'b1;
                  fault_port_d = port_q;
               end else begin
                  upd_vpn_d = vpn_q;
                  upd_ppn_d = jtlb.jtlb_utlb_ppn;
                  upd_flg_d = jtlb.jtlb_utlb_flg;
                  state_d   = ST_UPD;
               end
            end else if (clr) begin
               // Granted request cannot be withdrawn: remember to discard it
               drop_d = 1'b1;
            end
         end
         ST_UPD: begin
            state_d = ST_IDLE;
            if (!clr) begin
               upd_c    = victim;
               rr_ptr_d = rr_ptr_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and datapath registers
   always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q      <= ST_IDLE;
         vpn_q        <= '0;
         port_q       <= 1'b0;
         drop_q       <= 1'b0;
         upd_vpn_q    <= '0;
         upd_ppn_q    <= '0;
         upd_flg_q    <= '0;
         rr_ptr_q     <= '0;
         fault_vld_q  <= 1'b0;
         fault_port_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vpn_q        <= vpn_d;
         port_q       <= port_d;
         drop_q       <= drop_d;
         upd_vpn_q    <= upd_vpn_d;
         upd_ppn_q    <= upd_ppn_d;
         upd_flg_q    <= upd_flg_d;
         rr_ptr_q     <= rr_ptr_d;
         fault_vld_q  <= fault_vld_d;
         fault_port_q <= fault_port_d;
      end
   end

   assign jtlb.utlb_jtlb_req = req_c;
   assign jtlb.utlb_jtlb_vpn = vpn_q;
   assign utlb_entry_upd     = upd_c;
   assign utlb_upd_vpn       = upd_vpn_q;
   assign utlb_upd_ppn       = upd_ppn_q;
   assign utlb_upd_flg       = upd_flg_q;
   assign utlb_miss0         = miss0;
   assign utlb_miss1         = miss1;
   assign utlb_fault_vld     = fault_vld_q;
   assign utlb_fault_port    = fault_port_q;

`ifdef CT_MMU_DUTLB_MISS_CNT_EN
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating count of refill requests started from IDLE
   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if ((state_q == ST_IDLE) && (state_d == ST_REQ) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Miss counter register, cleared only by reset
   always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         miss_cnt_q <= '0;
      end else begin
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign utlb_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ct_mmu_dutlb_refill_ctrl.sv
// Directed bench for the data uTLB refill controller. Inputs change just
// after the rising edge; outputs are checked at the falling edge.
module tb_ct_mmu_dutlb_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [16:0] entry_vld, entry_hit0, entry_hit1;
   logic        lsu_req0_vld, lsu_req1_vld;
   logic [26:0] lsu_req_vpn0, lsu_req_vpn1;
   logic        regs_utlb_clr, tlboper_utlb_clr;
   logic [16:0] upd;
   logic [26:0] upd_vpn;
   logic [27:0] upd_ppn;
   logic [13:0] upd_flg;
   logic        miss0, miss1, fault_vld, fault_port;
`ifdef CT_MMU_DUTLB_MISS_CNT_EN
   logic [31:0] miss_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   ct_mmu_dutlb_refill_ctrl_if jtlb_if ();

   ct_mmu_dutlb_refill_ctrl dut (
      .utlb_entry_clk   (clk),
      .cpurst_b         (rst_b),
      .entry_vld        (entry_vld),
      .entry_hit0       (entry_hit0),
      .entry_hit1       (entry_hit1),
      .lsu_req0_vld     (lsu_req0_vld),
      .lsu_req1_vld     (lsu_req1_vld),
      .lsu_req_vpn0     (lsu_req_vpn0),
      .lsu_req_vpn1     (lsu_req_vpn1),
      .regs_utlb_clr    (regs_utlb_clr),
      .tlboper_utlb_clr (tlboper_utlb_clr),
      .jtlb             (jtlb_if),
      .utlb_entry_upd   (upd),
      .utlb_upd_vpn     (upd_vpn),
      .utlb_upd_ppn     (upd_ppn),
      .utlb_upd_flg     (upd_flg),
      .utlb_miss0       (miss0),
      .utlb_miss1       (miss1),
      .utlb_fault_vld   (fault_vld),
      .utlb_fault_port  (fault_port)
`ifdef CT_MMU_DUTLB_MISS_CNT_EN
      ,
      .utlb_miss_cnt    (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One refill from an IDLE cycle whose miss is already being driven:
   // grant in the first REQ cycle, refill in the first WAIT cycle.
   task automatic do_txn(input string tag, input logic [26:0] vpn,
                         input logic [27:0] ppn, input logic [16:0] exp_upd);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b1;
      @(negedge clk);
      chk({tag, "_req"}, jtlb_if.utlb_jtlb_req, 1'b1);
      chk({tag, "_jvpn"}, jtlb_if.utlb_jtlb_vpn, vpn);
      tick();
      jtlb_if.jtlb_utlb_grant      = 1'b0;
      jtlb_if.jtlb_utlb_refill_vld = 1'b1;
      jtlb_if.jtlb_utlb_ppn        = ppn;
      jtlb_if.jtlb_utlb_flg        = ppn[13:0];
      @(negedge clk);
      chk({tag, "_wait_req"}, jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b0;
      @(negedge clk);
      chk({tag, "_upd"}, upd, exp_upd);
      chk({tag, "_upd_vpn"}, upd_vpn, vpn);
      chk({tag, "_upd_ppn"}, upd_ppn, ppn);
      chk({tag, "_upd_flg"}, upd_flg, ppn[13:0]);
      tick();
   endtask

   initial begin
      rst_b = 1'b0;
      entry_vld = '0; entry_hit0 = '0; entry_hit1 = '0;
      lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
      lsu_req_vpn0 = '0; lsu_req_vpn1 = '0;
      regs_utlb_clr = 1'b0; tlboper_utlb_clr = 1'b0;
      jtlb_if.jtlb_utlb_grant = 1'b0;
      jtlb_if.jtlb_utlb_refill_vld = 1'b0;
      jtlb_if.jtlb_utlb_fault = 1'b0;
      jtlb_if.jtlb_utlb_ppn = '0;
      jtlb_if.jtlb_utlb_flg = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", jtlb_if.utlb_jtlb_req, 1'b0);
      chk("rst_jvpn", jtlb_if.utlb_jtlb_vpn, 27'h0);
      chk("rst_upd", upd, 17'h0);
      chk("rst_upd_ppn", upd_ppn, 28'h0);
      chk("rst_fault", fault_vld, 1'b0);
`ifdef CT_MMU_DUTLB_MISS_CNT_EN
      chk("rst_cnt", miss_cnt, 32'h0);
`endif
      rst_b = 1'b1;
      tick();

      // Test 1: port 0 miss, grant at t+2, refill at t+4, upd at t+5
      lsu_req0_vld = 1'b1; lsu_req_vpn0 = 27'h12345;
      @(negedge clk);
      chk("t1_miss0", miss0, 1'b1);
      chk("t1_idle_req", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      @(negedge clk);
      chk("t1_req_t1", jtlb_if.utlb_jtlb_req, 1'b1);
      chk("t1_jvpn", jtlb_if.utlb_jtlb_vpn, 27'h12345);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b1;
      @(negedge clk);
      chk("t1_req_t2", jtlb_if.utlb_jtlb_req, 1'b1);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b0;
      @(negedge clk);
      chk("t1_req_t3", jtlb_if.utlb_jtlb_req, 1'b0);
      chk("t1_upd_t3", upd, 17'h0);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b1;
      jtlb_if.jtlb_utlb_ppn = 28'hABCDE;
      jtlb_if.jtlb_utlb_flg = 14'h2A5;
      @(negedge clk);
      chk("t1_upd_t4", upd, 17'h0);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b0;
      jtlb_if.jtlb_utlb_ppn = '0;
      jtlb_if.jtlb_utlb_flg = '0;
      @(negedge clk);
      chk("t1_upd_t5", upd, 17'h1);
      chk("t1_upd_vpn", upd_vpn, 27'h12345);
      chk("t1_upd_ppn", upd_ppn, 28'hABCDE);
      chk("t1_upd_flg", upd_flg, 14'h2A5);
      tick();
      entry_vld = 17'h1; entry_hit0 = 17'h1;
      @(negedge clk);
      chk("t1_miss0_t6", miss0, 1'b0);
      chk("t1_upd_t6", upd, 17'h0);
      chk("t1_ppn_hold", upd_ppn, 28'hABCDE);
      tick();
      @(negedge clk);
      chk("t1_no_dup_req", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      lsu_req0_vld = 1'b0; entry_vld = '0; entry_hit0 = '0;

      // Test 2: both ports miss on different pages, port 0 first
      lsu_req0_vld = 1'b1; lsu_req1_vld = 1'b1;
      lsu_req_vpn0 = 27'h100; lsu_req_vpn1 = 27'h200;
      @(negedge clk);
      chk("t2_miss1", miss1, 1'b1);
      do_txn("t2a", 27'h100, 28'h111, 17'h1);
      entry_vld = 17'h1; entry_hit0 = 17'h1;
      @(negedge clk);
      chk("t2_miss0_after", miss0, 1'b0);
      chk("t2_miss1_after", miss1, 1'b1);
      do_txn("t2b", 27'h200, 28'h222, 17'h2);
      entry_vld = 17'h3; entry_hit1 = 17'h2;
      @(negedge clk);
      chk("t2_miss1_done", miss1, 1'b0);
      tick();
      @(negedge clk);
      chk("t2_idle_req", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      entry_vld = '0; entry_hit0 = '0; entry_hit1 = '0;

      // Test 2 rerun: same page on both ports gives one request only
      lsu_req_vpn1 = 27'h100;
      @(negedge clk);
      chk("t2s_miss1", miss1, 1'b1);
      do_txn("t2s", 27'h100, 28'h333, 17'h1);
      entry_vld = 17'h1; entry_hit0 = 17'h1; entry_hit1 = 17'h1;
      @(negedge clk);
      chk("t2s_miss1_hit", miss1, 1'b0);
      tick();
      @(negedge clk);
      chk("t2s_single_req", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
      entry_hit0 = '0; entry_hit1 = '0;

      // Test 3: all valid, round-robin victims 0..16 then wrap to 0
      entry_vld = '1;
      lsu_req0_vld = 1'b1;
      for (int i = 0; i < 18; i++) begin
         logic [16:0] exp_v;
         exp_v = 17'd1 << (i % 17);
         lsu_req_vpn0 = 27'h1000 + 27'(i);
         @(negedge clk);
         chk($sformatf("t3_miss_%0d", i), miss0, 1'b1);
         do_txn($sformatf("t3_%0d", i), 27'h1000 + 27'(i), 28'h2000 + 28'(i), exp_v);
      end
      lsu_req0_vld = 1'b0; entry_vld = '0;

      // Test 4: flush in WAIT, refill two cycles later is discarded
      lsu_req0_vld = 1'b1; lsu_req_vpn0 = 27'h300;
      @(negedge clk);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b1;
      @(negedge clk);
      chk("t4_req", jtlb_if.utlb_jtlb_req, 1'b1);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b0;
      tlboper_utlb_clr = 1'b1;
      @(negedge clk);
      chk("t4_upd_w0", upd, 17'h0);
      tick();
      tlboper_utlb_clr = 1'b0;
      @(negedge clk);
      chk("t4_req_w1", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b1;
      jtlb_if.jtlb_utlb_ppn = 28'h444;
      @(negedge clk);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b0;
      @(negedge clk);
      chk("t4_upd_drop", upd, 17'h0);
      chk("t4_fault_drop", fault_vld, 1'b0);
      chk("t4_idle_req", jtlb_if.utlb_jtlb_req, 1'b0);
      chk("t4_ppn_kept", upd_ppn, 28'h2011);
      do_txn("t4_retry", 27'h300, 28'h555, 17'h1);
      lsu_req0_vld = 1'b0;

      // Test 5: faulting refill on a port-1 miss
      lsu_req1_vld = 1'b1; lsu_req_vpn1 = 27'h400;
      @(negedge clk);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b1;
      @(negedge clk);
      chk("t5_jvpn", jtlb_if.utlb_jtlb_vpn, 27'h400);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b0;
      jtlb_if.jtlb_utlb_refill_vld = 1'b1;
      jtlb_if.jtlb_utlb_fault = 1'b1;
      @(negedge clk);
      chk("t5_fault_early", fault_vld, 1'b0);
      tick();
      jtlb_if.jtlb_utlb_refill_vld = 1'b0;
      jtlb_if.jtlb_utlb_fault = 1'b0;
      lsu_req1_vld = 1'b0;
      @(negedge clk);
      chk("t5_fault_vld", fault_vld, 1'b1);
      chk("t5_fault_port", fault_port, 1'b1);
      chk("t5_upd", upd, 17'h0);
      tick();
      @(negedge clk);
      chk("t5_fault_pulse_end", fault_vld, 1'b0);
      chk("t5_req", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();

      // Test 6: SATP flush while requesting withdraws the request
      lsu_req0_vld = 1'b1; lsu_req_vpn0 = 27'h500;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("t6_req", jtlb_if.utlb_jtlb_req, 1'b1);
      tick();
      regs_utlb_clr = 1'b1; lsu_req0_vld = 1'b0;
      @(negedge clk);
      chk("t6_req_clr", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();
      regs_utlb_clr = 1'b0;
      @(negedge clk);
      chk("t6_req_after", jtlb_if.utlb_jtlb_req, 1'b0);
      tick();

      // Test 7: asynchronous reset while waiting for a refill
      lsu_req0_vld = 1'b1; lsu_req_vpn0 = 27'h600;
      @(negedge clk);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b1;
      @(negedge clk);
      chk("t7_jvpn", jtlb_if.utlb_jtlb_vpn, 27'h600);
      tick();
      jtlb_if.jtlb_utlb_grant = 1'b0;
      lsu_req0_vld = 1'b0;
      #1 rst_b = 1'b0;
      #1;
      chk("t7_jvpn_rst", jtlb_if.utlb_jtlb_vpn, 27'h0);
      chk("t7_upd_vpn_rst", upd_vpn, 27'h0);
      chk("t7_upd_ppn_rst", upd_ppn, 28'h0);
      chk("t7_upd_flg_rst", upd_flg, 14'h0);
      chk("t7_fport_rst", fault_port, 1'b0);
      chk("t7_req_rst", jtlb_if.utlb_jtlb_req, 1'b0);
      chk("t7_upd_rst", upd, 17'h0);
`ifdef CT_MMU_DUTLB_MISS_CNT_EN
      chk("t7_cnt_rst", miss_cnt, 32'h0);
`endif
      @(negedge clk);
      rst_b = 1'b1;
      tick();
      @(negedge clk);
      chk("t7_idle_after", jtlb_if.utlb_jtlb_req, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
